// File: rtl/registrador_universal_n_pkg.sv
// Shared definitions for the universal N-bit register: manual operation codes
// and the serialiser FSM state encoding.
package registrador_universal_n_pkg;

  localparam logic [1:0] MODO_HOLD  = 2'b00;
  localparam logic [1:0] MODO_DIR   = 2'b01;
  localparam logic [1:0] MODO_ESQ   = 2'b10;
  localparam logic [1:0] MODO_CARGA = 2'b11;

  typedef enum logic {
    OCIOSO     = 1'b0,
    DESLOCANDO = 1'b1
  } estado_t;

endpackage

// File: rtl/registrador_universal_n_contador_bits.sv
// Synchronous mod-WIDTH bit counter; o_fim flags the last count so the
// serialiser knows the current shift is the final one of the frame.
module contador_bits #(
  parameter int WIDTH = 8,
  parameter int CW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic          i_clock,
  input  logic          i_clear,
  input  logic          i_enable,
  output logic [CW-1:0] o_contagem,
  output logic          o_fim
);

  logic [CW-1:0] r_contagem;
  logic          w_fim;

  assign w_fim      = (r_contagem == CW'(WIDTH - 1));
  assign o_fim      = w_fim;
  assign o_contagem = r_contagem;

  // Wraps to zero after the terminal count instead of running past WIDTH-1.
  always_ff @(posedge i_clock) begin
    if (i_clear) begin
      r_contagem <= '0;
    end else if (i_enable) begin
      if (w_fim) begin
        r_contagem <= '0;
      end else begin
        r_contagem <= r_contagem + 1'b1;
      end
    end
  end

endmodule

// File: rtl/registrador_universal_n.sv
// Universal N-bit register: hold / shift right / shift left / parallel load,
// plus an automatic serialiser that loads D and shifts out all WIDTH bits.
module registrador_universal_n
  import registrador_universal_n_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter bit               LSB_FIRST   = 1'b1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             enable,
  input  logic [1:0]       modo,
  input  logic [WIDTH-1:0] D,
  input  logic             serial_in_dir,
  input  logic             serial_in_esq,
  input  logic             iniciar,
  output logic [WIDTH-1:0] Q,
  output logic             serial_out,
  output logic             ocupado,
  output logic             pronto
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  estado_t          r_estado;
  estado_t          w_prox_estado;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_prox;
  logic [WIDTH-1:0] w_q_dir;
  logic [WIDTH-1:0] w_q_esq;
  logic             r_ocupado;
  logic             w_ocupado_prox;
  logic             r_pronto;
  logic             w_pronto_prox;
  logic             w_cnt_clr;
  logic             w_cnt_en;
  logic             w_fim;
  logic [CW-1:0]    w_contagem;

  assign w_q_dir = {serial_in_dir, r_q[WIDTH-1:1]};
  assign w_q_esq = {r_q[WIDTH-2:0], serial_in_esq};

  // Counter restarts on a new frame as well as on the global clear.
  contador_bits #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_contador (
    .i_clock    (clock),
    .i_clear    (clear | w_cnt_clr),
    .i_enable   (w_cnt_en),
    .o_contagem (w_contagem),
    .o_fim      (w_fim)
  );

  // pronto defaults low every cycle so it is a single-cycle pulse even when
  // enable drops right after the final shift.
  always_comb begin
    w_prox_estado  = r_estado;
    w_q_prox       = r_q;
    w_ocupado_prox = r_ocupado;
    w_pronto_prox  = 1'b0;
    w_cnt_clr      = 1'b0;
    w_cnt_en       = 1'b0;
    if (enable) begin
      case (r_estado)
        OCIOSO: begin
          if (iniciar) begin
            w_q_prox       = D;
            w_cnt_clr      = 1'b1;
            w_ocupado_prox = 1'b1;
            w_prox_estado  = DESLOCANDO;
          end else begin
            case (modo)
              MODO_DIR:   w_q_prox = w_q_dir;
              MODO_ESQ:   w_q_prox = w_q_esq;
              MODO_CARGA: w_q_prox = D;
              default:    w_q_prox = r_q;
            endcase
          end
        end
        DESLOCANDO: begin
          w_q_prox = LSB_FIRST ? w_q_dir : w_q_esq;
          w_cnt_en = 1'b1;
          if (w_fim) begin
            w_ocupado_prox = 1'b0;
            w_pronto_prox  = 1'b1;
            w_prox_estado  = OCIOSO;
          end
        end
        default: w_prox_estado = OCIOSO;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      r_estado  <= OCIOSO;
      r_q       <= RESET_VALUE;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
    end else begin
      r_estado  <= w_prox_estado;
      r_q       <= w_q_prox;
      r_ocupado <= w_ocupado_prox;
      r_pronto  <= w_pronto_prox;
    end
  end

  assign Q          = r_q;
  assign ocupado    = r_ocupado;
  assign pronto     = r_pronto;
  assign serial_out = LSB_FIRST ? r_q[0] : r_q[WIDTH-1];

endmodule

// File: tb/tb_registrador_universal_n.sv
// Self-checking bench for registrador_universal_n: manual modes, LSB-first
// serialiser (plain, stalled, aborted, back-to-back) and a 4-bit MSB-first copy.
module tb_registrador_universal_n;

  logic       clock = 1'b0;
  logic       clear, enable, sDir, sEsq, iniciar;
  logic [1:0] modo;
  logic [7:0] d;
  wire  [7:0] q;
  wire        serialOut, ocupado, pronto;

  logic       mClear, mEnable, mDir, mEsq, mIniciar;
  logic [1:0] mModo;
  logic [3:0] mD;
  wire  [3:0] mQ;
  wire        mSerial, mOcupado, mPronto;

  int testsRun    = 0;
  int testsFailed = 0;

  logic       bitQ[$];
  logic [7:0] qExp[$];
  logic       mBitQ[$];

  always #5 clock = ~clock;

  registrador_universal_n #(.WIDTH(8), .LSB_FIRST(1'b1)) u_dut (
    .clock(clock), .clear(clear), .enable(enable), .modo(modo), .D(d),
    .serial_in_dir(sDir), .serial_in_esq(sEsq), .iniciar(iniciar),
    .Q(q), .serial_out(serialOut), .ocupado(ocupado), .pronto(pronto)
  );

  registrador_universal_n #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
    .clock(clock), .clear(mClear), .enable(mEnable), .modo(mModo), .D(mD),
    .serial_in_dir(mDir), .serial_in_esq(mEsq), .iniciar(mIniciar),
    .Q(mQ), .serial_out(mSerial), .ocupado(mOcupado), .pronto(mPronto)
  );

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] e;
    enable = 1'b1; modo = 2'b11; d = 8'hA5;
    qExp.push_back(8'hA5);
    step();
    e = qExp.pop_front();
    testsRun++;
    if (q !== e) begin testsFailed++; $display("[TB] FAIL preload_q: got %h expected %h", q, e); end
    modo = 2'b00; clear = 1'b1;
    step();
    clear = 1'b0;
    testsRun++;
    if (q !== 8'h00) begin testsFailed++; $display("[TB] FAIL reset_q: got %h expected 00", q); end
    testsRun++;
    if (ocupado !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_ocupado: got %b expected 0", ocupado); end
    testsRun++;
    if (pronto !== 1'b0) begin testsFailed++; $display("[TB] FAIL reset_pronto: got %b expected 0", pronto); end
  endtask

  task automatic test_manual_modes();
    logic [1:0] modos[6] = '{2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
    logic [7:0] exps[6]  = '{8'h3C, 8'h9E, 8'h3C, 8'h3C, 8'h3C, 8'h3C};
    logic [7:0] e;
    enable = 1'b1; d = 8'h3C; sDir = 1'b1; sEsq = 1'b0;
    for (int i = 0; i < 6; i++) begin
      modo = modos[i];
      qExp.push_back(exps[i]);
      step();
      e = qExp.pop_front();
      testsRun++;
      if (q !== e) begin testsFailed++; $display("[TB] FAIL manual_step%0d: got %h expected %h", i, q, e); end
    end
    enable = 1'b0; modo = 2'b11; d = 8'hFF;
    qExp.push_back(8'h3C);
    step();
    e = qExp.pop_front();
    testsRun++;
    if (q !== e) begin testsFailed++; $display("[TB] FAIL enable_low_hold: got %h expected %h", q, e); end
    enable = 1'b1; modo = 2'b00; sDir = 1'b0;
  endtask

  task automatic start_frame(input logic [7:0] data);
    d = data; iniciar = 1'b1; enable = 1'b1;
    for (int i = 0; i < 8; i++) bitQ.push_back(data[i]);
    step();
    iniciar = 1'b0;
    testsRun++;
    if (ocupado !== 1'b1) begin testsFailed++; $display("[TB] FAIL start_ocupado: got %b expected 1", ocupado); end
    testsRun++;
    if (q !== data) begin testsFailed++; $display("[TB] FAIL start_load: got %h expected %h", q, data); end
  endtask

  task automatic run_frame(input int stallBit, input int stallCycles, input bit chain,
                           input logic [7:0] nextD, output int ocCycles);
    int   bitIdx    = 0;
    int   stallLeft = stallCycles;
    bit   done      = 1'b0;
    logic expBit;
    ocCycles = 0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      if (ocupado) begin
        ocCycles++;
        testsRun++;
        if (bitQ.size() == 0) begin
          testsFailed++; $display("[TB] FAIL serial_extra_bit: got ocupado=1 expected 0");
        end else begin
          expBit = bitQ[0];
          if (serialOut !== expBit) begin
            testsFailed++; $display("[TB] FAIL serial_bit%0d: got %b expected %b", bitIdx, serialOut, expBit);
          end
        end
        if (bitIdx == stallBit && stallLeft > 0) begin
          enable = 1'b0; stallLeft--;
        end else begin
          enable = 1'b1;
          if (bitQ.size() > 0) void'(bitQ.pop_front());
          bitIdx++;
        end
        step();
      end else begin
        testsRun++;
        if (pronto !== 1'b1) begin testsFailed++; $display("[TB] FAIL pronto_pulse: got %b expected 1", pronto); end
        testsRun++;
        if (bitQ.size() != 0) begin testsFailed++; $display("[TB] FAIL bits_left: got %0d expected 0", bitQ.size()); end
        if (chain) begin
          d = nextD; iniciar = 1'b1; enable = 1'b1;
          for (int i = 0; i < 8; i++) bitQ.push_back(nextD[i]);
          step();
          iniciar = 1'b0;
          testsRun++;
          if (ocupado !== 1'b1) begin testsFailed++; $display("[TB] FAIL chain_ocupado: got %b expected 1", ocupado); end
          testsRun++;
          if (q !== nextD) begin testsFailed++; $display("[TB] FAIL chain_load: got %h expected %h", q, nextD); end
        end else begin
          step();
          testsRun++;
          if (pronto !== 1'b0) begin testsFailed++; $display("[TB] FAIL pronto_width: got %b expected 0", pronto); end
        end
        done = 1'b1;
      end
    end
    enable = 1'b1;
    if (!done) begin
      testsRun++; testsFailed++;
      $display("[TB] FAIL frame_timeout: got ocupado=%b expected 0 within 40 cycles", ocupado);
    end
  endtask

  task automatic test_serialise();
    int oc;
    start_frame(8'b1011_0010);
    run_frame(-1, 0, 1'b0, 8'h00, oc);
    testsRun++;
    if (oc != 8) begin testsFailed++; $display("[TB] FAIL serialise_length: got %0d expected 8", oc); end
  endtask

  task automatic test_stall();
    int oc;
    start_frame(8'b1011_0010);
    run_frame(3, 3, 1'b0, 8'h00, oc);
    testsRun++;
    if (oc != 11) begin testsFailed++; $display("[TB] FAIL stall_length: got %0d expected 11", oc); end
  endtask

  task automatic test_abort();
    start_frame(8'b1011_0010);
    for (int i = 0; i < 4; i++) step();
    clear = 1'b1;
    step();
    clear = 1'b0;
    bitQ.delete();
    testsRun++;
    if (q !== 8'h00) begin testsFailed++; $display("[TB] FAIL abort_q: got %h expected 00", q); end
    testsRun++;
    if (ocupado !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_ocupado: got %b expected 0", ocupado); end
    for (int i = 0; i < 3; i++) begin
      testsRun++;
      if (pronto !== 1'b0) begin testsFailed++; $display("[TB] FAIL abort_pronto%0d: got %b expected 0", i, pronto); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    int oc;
    start_frame(8'hC3);
    run_frame(-1, 0, 1'b1, 8'h5A, oc);
    testsRun++;
    if (oc != 8) begin testsFailed++; $display("[TB] FAIL b2b_first_length: got %0d expected 8", oc); end
    run_frame(-1, 0, 1'b0, 8'h00, oc);
    testsRun++;
    if (oc != 8) begin testsFailed++; $display("[TB] FAIL b2b_second_length: got %0d expected 8", oc); end
  endtask

  task automatic test_msb_first();
    int   oc   = 0;
    bit   done = 1'b0;
    logic e;
    mD = 4'b1100; mEsq = 1'b1; mEnable = 1'b1; mIniciar = 1'b1;
    for (int i = 3; i >= 0; i--) mBitQ.push_back(mD[i]);
    step();
    mIniciar = 1'b0;
    for (int cyc = 0; cyc < 12 && !done; cyc++) begin
      if (mOcupado) begin
        e = (mBitQ.size() > 0) ? mBitQ.pop_front() : 1'bx;
        testsRun++;
        if (mSerial !== e) begin testsFailed++; $display("[TB] FAIL msb_bit%0d: got %b expected %b", oc, mSerial, e); end
        oc++;
        step();
      end else begin
        done = 1'b1;
      end
    end
    testsRun++;
    if (oc != 4) begin testsFailed++; $display("[TB] FAIL msb_length: got %0d expected 4", oc); end
    testsRun++;
    if (mQ !== 4'b1111) begin testsFailed++; $display("[TB] FAIL msb_final_q: got %b expected 1111", mQ); end
    testsRun++;
    if (mPronto !== 1'b1) begin testsFailed++; $display("[TB] FAIL msb_pronto: got %b expected 1", mPronto); end
  endtask

  initial begin
    clear = 1'b1; enable = 1'b0; modo = 2'b00; d = 8'h00;
    sDir = 1'b0; sEsq = 1'b0; iniciar = 1'b0;
    mClear = 1'b1; mEnable = 1'b0; mModo = 2'b00; mD = 4'h0;
    mDir = 1'b0; mEsq = 1'b0; mIniciar = 1'b0;
    step();
    step();
    clear = 1'b0; mClear = 1'b0;
    test_reset();
    test_manual_modes();
    test_serialise();
    test_stall();
    test_abort();
    test_back_to_back();
    test_msb_first();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
